prime_tester: RTL and testbench

Sequential trial-division primality tester that serves the problem-solver top levels, which search candidate values and need a yes/no primality answer per value. It accepts a 32-bit candidate under a level start/done handshake, runs trial division with a serial remainder unit, and holds a registered verdict until the requester releases `start`. The block is the direct downstream consumer of the solver's `value`/`start` pair and the producer of its `result`/`done` inputs.

---
 rtl/euler_pkg.sv | 26 ++
 rtl/prime_tester_if.sv | 14 +
 rtl/prime_tester_seq_mod32.sv | 66 ++++++
 rtl/prime_tester.sv | 169 ++++++++++++++++
 tb/tb_prime_tester.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/euler_pkg.sv
// Shared types and sizes for the problem-solver blocks.
// PRIME_TESTER_WHEEL6_EN enables the 6k+-1 wheel helper below.
package euler_pkg;

  localparam int unsigned PRIME_W    = 32;
  localparam int unsigned DIV_CYCLES = 33;
  localparam int unsigned D_W        = PRIME_W + 1;
  localparam int unsigned SQ_W       = 2 * PRIME_W;

  typedef enum logic [2:0] {
    IDLE,
    SMALL,
    LAUNCH,
    DIV,
    NEXT,
    DONE
  } prime_state_t;

`ifdef PRIME_TESTER_WHEEL6_EN
  // Combinational multiple-of-3 test, kept out of the serial divider.
  function automatic logic is_mult3(input logic [PRIME_W-1:0] x);
    return (x % PRIME_W'(3)) == '0;
  endfunction
`endif

endpackage

// File: rtl/prime_tester_if.sv
// Request/verdict handshake between a solver and prime_tester.
interface prime_tester_if;
  import euler_pkg::*;

  logic               start;
  logic [PRIME_W-1:0] value;
  logic               result;
  logic               done;
  logic               busy;

  modport master (output start, output value, input result, input done, input busy);
  modport slave  (input start, input value, output result, output done, output busy);

endinterface

// File: rtl/prime_tester_seq_mod32.sv
// seq_mod32: restoring serial remainder, one quotient bit per cycle.
// div_done pulses for one cycle DIV_CYCLES cycles after div_start.
module seq_mod32
  import euler_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               div_start,
  input  logic [PRIME_W-1:0] dividend,
  input  logic [PRIME_W-1:0] divisor,
  output logic [PRIME_W-1:0] remainder,
  output logic               div_done
);

  localparam int unsigned ITER  = DIV_CYCLES - 1;
  localparam int unsigned CNT_W = 6;

  logic               running;
  logic [CNT_W-1:0]   cnt;
  logic [PRIME_W-1:0] acc;
  logic [PRIME_W-1:0] shreg;
  logic [PRIME_W-1:0] dsr;
  logic [PRIME_W:0]   partial;
  logic               fits;
  logic [PRIME_W-1:0] acc_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    partial  = {acc, shreg[PRIME_W-1]};
    fits     = partial >= {1'b0, dsr};
    acc_next = fits ? PRIME_W'(partial - {1'b0, dsr}) : partial[PRIME_W-1:0];
  end

  // Iteration control; the last step also registers the remainder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      shreg     <= '0;
      dsr       <= '0;
      remainder <= '0;
      div_done  <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        running <= 1'b1;
        cnt     <= '0;
        acc     <= '0;
        shreg   <= dividend;
        dsr     <= divisor;
      end else if (running) begin
        acc   <= acc_next;
        shreg <= shreg << 1;
        if (cnt == CNT_W'(ITER - 1)) begin
          remainder <= acc_next;
          div_done  <= 1'b1;
          running   <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/prime_tester.sv
// prime_tester: trial-division primality test under a start/done level handshake.
// Define PRIME_TESTER_WHEEL6_EN for the 6k+-1 wheel (same verdicts, lower latency).
module prime_tester
  import euler_pkg::*;
#(
  parameter int unsigned WIDTH = PRIME_W
) (
  input  logic           clk,
  input  logic           rst_n,
  prime_tester_if.slave  bus
);

`ifdef PRIME_TESTER_WHEEL6_EN
  localparam logic [D_W-1:0]  D_INIT  = D_W'(5);
  localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(25);
`else
  localparam logic [D_W-1:0]  D_INIT  = D_W'(3);
  localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(9);
`endif

  prime_state_t       state, state_next;
  logic [WIDTH-1:0]   n, n_next;
  logic [D_W-1:0]     d, d_next;
  logic [SQ_W-1:0]    sq, sq_next;
  logic               result, result_next;
  logic               done, done_next;
  logic               busy, busy_next;
  logic               div_start;
  logic               div_done;
  logic [PRIME_W-1:0] remainder;
`ifdef PRIME_TESTER_WHEEL6_EN
  logic               step4, step4_next;
`endif

  seq_mod32 u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_start (div_start),
    .dividend  (n),
    .divisor   (d[PRIME_W-1:0]),
    .remainder (remainder),
    .div_done  (div_done)
  );

  // Next-state, datapath updates and registered-output targets.
  always_comb begin
    state_next  = state;
    n_next      = n;
    d_next      = d;
    sq_next     = sq;
    result_next = result;
    div_start   = 1'b0;
`ifdef PRIME_TESTER_WHEEL6_EN
    step4_next  = step4;
`endif

    case (state)
      IDLE: begin
        if (bus.start) begin
          n_next     = bus.value;
          state_next = SMALL;
        end
      end
      SMALL: begin
        state_next = DONE;
        if (n < WIDTH'(2)) begin
          result_next = 1'b0;
        end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
          result_next = 1'b1;
        end else if (!n[0]) begin
          result_next = 1'b0;
`ifdef PRIME_TESTER_WHEEL6_EN
        end else if (is_mult3(n)) begin
          result_next = 1'b0;
`endif
        end else begin
          d_next     = D_INIT;
          sq_next    = SQ_INIT;
          state_next = LAUNCH;
`ifdef PRIME_TESTER_WHEEL6_EN
          step4_next = 1'b0;
`endif
        end
      end
      LAUNCH: begin
        if (sq > SQ_W'(n)) begin
          result_next = 1'b1;
          state_next  = DONE;
        end else begin
          div_start  = 1'b1;
          state_next = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          if (remainder == '0) begin
            result_next = 1'b0;
            state_next  = DONE;
          end else begin
            state_next = NEXT;
          end
        end
      end
      NEXT: begin
        // (d+s)^2 = d^2 + 2sd + s^2 with s = 2 or 4.
`ifdef PRIME_TESTER_WHEEL6_EN
        if (step4) begin
          sq_next = sq + (SQ_W'(d) << 3) + SQ_W'(16);
          d_next  = d + D_W'(4);
        end else begin
          sq_next = sq + (SQ_W'(d) << 2) + SQ_W'(4);
          d_next  = d + D_W'(2);
        end
        step4_next = !step4;
`else
        sq_next = sq + (SQ_W'(d) << 2) + SQ_W'(4);
        d_next  = d + D_W'(2);
`endif
        state_next = LAUNCH;
      end
      DONE: begin
        if (!bus.start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Requester withdrew mid-test: abandon the work, keep the old verdict.
    if ((state inside {SMALL, LAUNCH, DIV, NEXT}) && !bus.start) begin
      state_next  = IDLE;
      result_next = result;
      div_start   = 1'b0;
    end

    done_next = (state_next == DONE);
    busy_next = !(state_next inside {IDLE, DONE});
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      n      <= '0;
      d      <= '0;
      sq     <= '0;
      result <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
`ifdef PRIME_TESTER_WHEEL6_EN
      step4  <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      n      <= n_next;
      d      <= d_next;
      sq     <= sq_next;
      result <= result_next;
      done   <= done_next;
      busy   <= busy_next;
`ifdef PRIME_TESTER_WHEEL6_EN
      step4  <= step4_next;
`endif
    end
  end

  assign bus.result = result;
  assign bus.done   = done;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_prime_tester.sv
// Directed bench for prime_tester: trivial cases, trial division, abort and reset.
module tb_prime_tester;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  prime_tester_if bus ();

  prime_tester dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef PRIME_TESTER_WHEEL6_EN
  localparam int LAT_11     = 3;
  localparam int LAT_97     = 73;
  localparam int LAT_13     = 3;
  localparam int LAT_104729 = 3748;
`else
  localparam int LAT_11     = 38;
  localparam int LAT_97     = 143;
  localparam int LAT_13     = 38;
  localparam int LAT_104729 = 5638;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One full handshake; entered and left on a falling edge. exp_lat = 0 skips latency.
  task automatic run_req(input string tag, input logic [31:0] v, input logic exp_res,
                         input int exp_lat);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 0;
    bus.value = v;
    bus.start = 1'b1;
    while (!seen && cnt < 20000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.value = ~v;
      end
      if (bus.done) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    bit rose;
    clk       = 1'b0;
    rst_n     = 1'b0;
    n_checks  = 0;
    n_pass    = 0;
    bus.start = 1'b0;
    bus.value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    rst_n = 1'b1;
    wait_cycles(1);

    run_req("v0",     32'd0,          1'b0, 2);
    run_req("v1",     32'd1,          1'b0, 2);
    run_req("v4",     32'd4,          1'b0, 2);
    run_req("v2",     32'd2,          1'b1, 2);
    run_req("v3",     32'd3,          1'b1, 2);
    run_req("v2p31",  32'h8000_0000,  1'b0, 2);
    run_req("v7",     32'd7,          1'b1, 3);
    run_req("v11",    32'd11,         1'b1, LAT_11);
    run_req("v9",     32'd9,          1'b0, 0);
    run_req("v25",    32'd25,         1'b0, 0);
    run_req("v49",    32'd49,         1'b0, 0);
    run_req("v121",   32'd121,        1'b0, 0);
    run_req("vmax",   32'hFFFF_FFFF,  1'b0, 0);
    run_req("v104729", 32'd104729,    1'b1, LAT_104729);
    run_req("v97",    32'd97,         1'b1, LAT_97);

    // Abort mid-division: verdict from 97 must survive, done must stay low.
    bus.value = 32'd1000003;
    bus.start = 1'b1;
    wait_cycles(20);
    check("abort_busy_mid", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_cycles(1);
    check("abort_busy", 32'(bus.busy),   32'd0);
    check("abort_done", 32'(bus.done),   32'd0);
    check("abort_hold", 32'(bus.result), 32'd1);
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      wait_cycles(1);
      if (bus.done) rose = 1;
    end
    check("abort_no_done", 32'(rose), 32'd0);
    run_req("after_abort7", 32'd7, 1'b1, 3);

    // Reset mid-division clears every output on the next cycle.
    bus.value = 32'd1000003;
    bus.start = 1'b1;
    wait_cycles(20);
    rst_n     = 1'b0;
    bus.start = 1'b0;
    wait_cycles(1);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_done",   32'(bus.done),   32'd0);
    check("mid_rst_busy",   32'(bus.busy),   32'd0);
    rst_n = 1'b1;
    wait_cycles(1);
    run_req("after_rst13", 32'd13, 1'b1, LAT_13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
